// File: rtl/uart_ctrl.sv
// Register-mapped d16 bus front end for the uart core: TX/RX FIFOs, TX handshake FSM, sticky status, CLKDIV.
// Optional interrupt output and CTRL[9:8] enables are built when UART_CTRL_IRQ_EN is defined.
module uart_ctrl #(
    parameter int          FIFO_DEPTH_LOG2 = 4,
    parameter logic [15:0] DEFAULT_DIV     = 16'd1302
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [1:0]  addr,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [15:0] wdata,
    output logic [15:0] rdata,
    output logic        uart_transmit,
    output logic [7:0]  uart_tx_byte,
    output logic [15:0] uart_clk_div,
    input  logic        uart_is_transmitting,
    input  logic        uart_received,
    input  logic [7:0]  uart_rx_byte,
    input  logic        uart_recv_error
`ifdef UART_CTRL_IRQ_EN
    ,output logic       irq
`endif
);

    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam int PW    = FIFO_DEPTH_LOG2 + 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT_BUSY, S_WAIT_DONE} state_t;

    state_t         r_state;
    state_t         w_state_d;

    logic [7:0]     r_tx_mem [DEPTH];
    logic [7:0]     r_rx_mem [DEPTH];
    logic [PW-1:0]  r_tx_wp, r_tx_rp, r_rx_wp, r_rx_rp;
    logic           r_transmit;
    logic [7:0]     r_tx_byte;
    logic [15:0]    r_clk_div;
    logic [15:0]    r_rdata;
    logic           r_tx_en, r_rx_en;
    logic           r_rx_ovf, r_frame_err, r_tx_ovf;
    logic           r_rx_ie, r_txe_ie;

    logic           w_wr_data, w_rd_data, w_wr_stat, w_wr_div, w_wr_ctrl;
    logic           w_tx_empty, w_tx_full, w_rx_empty, w_rx_full;
    logic           w_tx_pop, w_tx_push, w_tx_flush, w_tx_ovf_set;
    logic           w_rx_req, w_rx_pop, w_rx_push, w_rx_flush, w_rx_ovf_set;
    logic           w_tx_busy;
    logic [15:0]    w_status, w_ctrl;

    assign w_wr_data = wr_en && (addr == 2'd0);
    assign w_rd_data = rd_en && (addr == 2'd0);
    assign w_wr_stat = wr_en && (addr == 2'd1);
    assign w_wr_div  = wr_en && (addr == 2'd2);
    assign w_wr_ctrl = wr_en && (addr == 2'd3);

    assign w_tx_empty = (r_tx_wp == r_tx_rp);
    assign w_tx_full  = (r_tx_wp[PW-1] != r_tx_rp[PW-1]) && (r_tx_wp[PW-2:0] == r_tx_rp[PW-2:0]);
    assign w_rx_empty = (r_rx_wp == r_rx_rp);
    assign w_rx_full  = (r_rx_wp[PW-1] != r_rx_rp[PW-1]) && (r_rx_wp[PW-2:0] == r_rx_rp[PW-2:0]);

    assign w_tx_flush = w_wr_ctrl && wdata[2];
    assign w_rx_flush = w_wr_ctrl && wdata[3];

    // A pop only exists when non-empty, so a full FIFO with a pop can still accept a push
    assign w_tx_pop     = (r_state == S_IDLE) && r_tx_en && !w_tx_empty && !uart_is_transmitting;
    assign w_tx_push    = w_wr_data && (!w_tx_full || w_tx_pop);
    assign w_tx_ovf_set = w_wr_data && w_tx_full && !w_tx_pop;

    assign w_rx_req     = uart_received && r_rx_en;
    assign w_rx_pop     = w_rd_data && !w_rx_empty;
    assign w_rx_push    = w_rx_req && (!w_rx_full || w_rx_pop);
    assign w_rx_ovf_set = w_rx_req && w_rx_full && !w_rx_pop;

    assign w_tx_busy = (r_state != S_IDLE) || uart_is_transmitting;
    assign w_status  = {8'h00, r_tx_ovf, r_frame_err, r_rx_ovf, w_tx_busy,
                        w_tx_full, w_tx_empty, w_rx_full, !w_rx_empty};
    assign w_ctrl    = {6'b0, r_txe_ie, r_rx_ie, 6'b0, r_rx_en, r_tx_en};

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            S_IDLE:      if (w_tx_pop) w_state_d = S_START;
            S_START:     w_state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: if (uart_is_transmitting) w_state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (!uart_is_transmitting) w_state_d = S_IDLE;
            default:     w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_transmit <= 1'b0;
            r_tx_byte  <= '0;
        end else begin
            r_state    <= w_state_d;
            r_transmit <= (w_state_d == S_START);
            if (w_tx_pop) r_tx_byte <= r_tx_mem[r_tx_rp[PW-2:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (w_tx_push) r_tx_mem[r_tx_wp[PW-2:0]] <= wdata[7:0];
        if (w_rx_push) r_rx_mem[r_rx_wp[PW-2:0]] <= uart_rx_byte;
    end

    // Flush overrides both push and pop in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_wp <= '0;
            r_tx_rp <= '0;
            r_rx_wp <= '0;
            r_rx_rp <= '0;
        end else begin
            if (w_tx_flush) begin
                r_tx_wp <= '0;
                r_tx_rp <= '0;
            end else begin
                if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
                if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
            end
            if (w_rx_flush) begin
                r_rx_wp <= '0;
                r_rx_rp <= '0;
            end else begin
                if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
                if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_ovf    <= 1'b0;
            r_frame_err <= 1'b0;
            r_tx_ovf    <= 1'b0;
        end else begin
            r_rx_ovf    <= w_rx_ovf_set    || (r_rx_ovf    && !(w_wr_stat && wdata[5]));
            r_frame_err <= uart_recv_error || (r_frame_err && !(w_wr_stat && wdata[6]));
            r_tx_ovf    <= w_tx_ovf_set    || (r_tx_ovf    && !(w_wr_stat && wdata[7]));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clk_div <= DEFAULT_DIV;
            r_tx_en   <= 1'b1;
            r_rx_en   <= 1'b1;
            r_rx_ie   <= 1'b0;
            r_txe_ie  <= 1'b0;
        end else begin
            if (w_wr_div) r_clk_div <= (wdata == 16'h0000) ? 16'd1 : wdata;
            if (w_wr_ctrl) begin
                r_tx_en <= wdata[0];
                r_rx_en <= wdata[1];
`ifdef UART_CTRL_IRQ_EN
                r_rx_ie  <= wdata[8];
                r_txe_ie <= wdata[9];
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata <= '0;
        end else if (rd_en) begin
            case (addr)
                2'd0:    r_rdata <= w_rx_empty ? 16'h0000 : {8'h00, r_rx_mem[r_rx_rp[PW-2:0]]};
                2'd1:    r_rdata <= w_status;
                2'd2:    r_rdata <= r_clk_div;
                default: r_rdata <= w_ctrl;
            endcase
        end
    end

`ifdef UART_CTRL_IRQ_EN
    logic r_irq;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_irq <= 1'b0;
        else        r_irq <= (r_rx_ie && !w_rx_empty) ||
                             (r_txe_ie && w_tx_empty && (r_state == S_IDLE)) ||
                             r_rx_ovf || r_frame_err;
    end
    assign irq = r_irq;
`endif

    assign rdata         = r_rdata;
    assign uart_transmit = r_transmit;
    assign uart_tx_byte  = r_tx_byte;
    assign uart_clk_div  = r_clk_div;

endmodule

// File: doc/uart_ctrl.md
# uart_ctrl

Register-mapped controller that sits between the d16 CPU bus and the `uart` core. It buffers outgoing bytes in a TX FIFO and sequences the core's single-cycle `transmit` handshake. It captures received bytes and errors into an RX FIFO with sticky status flags, and it owns the core's clock-divisor setting.

## Interface
- `FIFO_DEPTH_LOG2`, default 4: log2 of the depth of each FIFO (16 entries).
- `DEFAULT_DIV`, default 1302: reset value of the CLKDIV register.
- `clk` in 1: system clock; every flop is clocked on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `addr` in 2: register select. 0 = DATA, 1 = STATUS, 2 = CLKDIV, 3 = CTRL.
- `wr_en` in 1: write strobe, one cycle per access.
- `rd_en` in 1: read strobe, one cycle per access.
- `wdata` in 16: write data.
- `rdata` out 16: registered read data, valid the cycle after `rd_en`.
- `uart_transmit` out 1: drives the core's `transmit`.
- `uart_tx_byte` out 8: drives the core's `tx_byte`.
- `uart_clk_div` out 16: drives the core's `clk_div_in`.
- `uart_is_transmitting` in 1: from the core.
- `uart_received` in 1: from the core; a one-cycle pulse.
- `uart_rx_byte` in 8: from the core.
- `uart_recv_error` in 1: from the core; a one-cycle pulse.
- `irq` out 1: interrupt output; present only with `UART_CTRL_IRQ_EN`.

## Operation
**DATA register (addr 0)**
- Write pushes `wdata[7:0]` into the TX FIFO.
  - If the TX FIFO is full, the byte is dropped and `tx_ovf` is set.
- Read returns `{8'h00, rx_head}` and pops the RX FIFO.
  - If the RX FIFO is empty, the read returns `16'h0000` and nothing is popped.

**STATUS register (addr 1)**
- Bit 0 `rx_nonempty`, bit 1 `rx_full`, bit 2 `tx_empty`, bit 3 `tx_full`.
- Bit 4 `tx_busy` = (FSM != IDLE) || `uart_is_transmitting`.
- Bits 5, 6 and 7 are sticky: 5 `rx_ovf`, 6 `frame_err`, 7 `tx_ovf`.
  - Writing 1 to a sticky bit clears it.
  - If a set event and a clear hit the same cycle, the set wins.

**CLKDIV register (addr 2)**
- Read/write, 16 bits, driven straight onto `uart_clk_div`.
- A write of 0 is stored as 1.
- The core adopts the new value only while both of its state machines are idle; the controller does not gate this.

**CTRL register (addr 3)**
- Bit 0 `tx_en`, reset 1.
- Bit 1 `rx_en`, reset 1.
- Bit 2 `tx_flush`: write-1, self-clearing; empties the TX FIFO.
- Bit 3 `rx_flush`: write-1, self-clearing; empties the RX FIFO.
- Bits 8 and 9 are the interrupt enables (see Configuration).

**Receive path**
- On `uart_received` with `rx_en`=1, `uart_rx_byte` is pushed into the RX FIFO.
  - If the RX FIFO is full (and no pop happens in the same cycle), the byte is dropped and `rx_ovf` is set.
- On `uart_recv_error`, `frame_err` is set regardless of `rx_en`.
- With `rx_en`=0, `uart_received` is ignored.

**TX state machine**
- IDLE → START when `tx_en` && TX FIFO non-empty && !`uart_is_transmitting`.
  - On this transition, pop the FIFO head into `uart_tx_byte` and set `uart_transmit`=1.
- START → WAIT_BUSY, clearing `uart_transmit`. `uart_transmit` is therefore high for exactly one cycle.
- WAIT_BUSY → WAIT_DONE when `uart_is_transmitting`=1.
- WAIT_DONE → IDLE when `uart_is_transmitting`=0.
- Clearing `tx_en` takes effect only in IDLE; a byte already handed to the core completes.

**Boundary rules**
- Push and pop of the same FIFO in one cycle is legal even when the FIFO is full or empty; the count is unchanged.
  - Empty case: the push lands and the pop is ignored.
- A flush in the same cycle as a push: the flush wins and the pushed byte is discarded.
- FIFO pointers are `FIFO_DEPTH_LOG2`+1 bits wide and wrap naturally. Full = MSBs differ and the rest are equal.
- Asserting `rst_n` low mid-frame returns the FSM to IDLE and empties both FIFOs. The core is reset separately; the controller makes no attempt to finish the frame.

## Timing
- Reset values: `rdata`=0, `uart_transmit`=0, `uart_tx_byte`=0, `uart_clk_div`=`DEFAULT_DIV`, `irq`=0.
- All FIFOs and sticky flags are reset to empty/0.
- `rdata`: one-cycle latency. The pop takes effect at the same edge that samples `rd_en`.
- TX latency, for a DATA write sampled at edge E0 into an empty FIFO with the FSM in IDLE:
  - `uart_transmit` rises at E1 and falls at E2.
  - `uart_tx_byte` is stable from E1 until the next pop.
- Back-to-back bytes: the next `uart_transmit` comes no earlier than one cycle after `uart_is_transmitting` falls.
- `wr_en` and `rd_en` may be asserted together on different registers. They must not both target DATA in the same cycle; if they do, both the push and the pop occur.

## Configuration
- `UART_CTRL_IRQ_EN` defined:
  - The `irq` port and CTRL bits 8 (`rx_ie`) and 9 (`txe_ie`) exist; both enables reset to 0.
  - `irq` is registered: `irq` = (`rx_ie` && `rx_nonempty`) || (`txe_ie` && `tx_empty` && FSM==IDLE) || `rx_ovf` || `frame_err`.
- `UART_CTRL_IRQ_EN` undefined:
  - No `irq` port.
  - CTRL bits 8 and 9 read 0 and ignore writes.

## Test plan
- Write 0x41 to DATA after reset → `uart_transmit` high for exactly one cycle starting 1 cycle after the write, with `uart_tx_byte`=0x41.
  - STATUS.`tx_busy`=1 until `uart_is_transmitting` falls.
- Write 17 bytes (0x00..0x10) with the `uart_is_transmitting` model held high → STATUS.`tx_full`=1 and `tx_ovf`=1.
  - Release busy → 16 transmits carrying 0x00..0x0F in order.
- Pulse `uart_received` 17 times with 0x80..0x90 and no reads → `rx_ovf`=1.
  - 16 DATA reads return 0x0080..0x008F; the 17th read returns 0x0000.
- Read DATA and pulse `uart_received` (0x55) in the same cycle with the RX FIFO full → count unchanged, `rx_ovf` stays 0, and 0x55 is the last entry.
- Write 0 to CLKDIV → CLKDIV reads back 1 and `uart_clk_div`=1.
  - Pulse `uart_recv_error` while writing 0x0040 to STATUS → `frame_err` remains 1.
- With `UART_CTRL_IRQ_EN`: set `rx_ie`, pulse `uart_received` (0x12) → `irq`=1 the next cycle.
  - Read DATA → `irq`=0 one cycle after the FIFO empties.
  - Drop `rst_n` mid-transmit → every output returns to its reset value immediately (asynchronously).
